// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART blocks.
//   uart_tx_state_t : transmitter FSM states
//   PAR_*           : parity selection constants
//   frame_cycles()  : clock cycles in one complete frame for a given configuration
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int frame_cycles(input int div, input int bits, input int par, input int stop);
    return (1 + bits + ((par != PAR_NONE) ? 1 : 0) + stop) * div;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period divider.
// The counter runs 0..CLK_DIV-1 and flags bit_end on the last count. It then
// wraps to zero, so consecutive bit periods follow on without a gap.
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   clr     in  hold the counter at zero
//   bit_end out high on the final cycle of each bit period
module uart_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int              CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    // NOTE: give every always_comb output a default first so that no path leaves it unassigned, which would infer a latch.
    cnt_d = cnt_q + CW'(1);
    if (clr || bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter.
// Accepts one byte per valid/ready handshake. Sends a start bit, then the
// data bits LSB first, then optional parity, then the stop bit(s). The idle
// level of the line is high.
//   clk       in   system clock
//   rst       in   synchronous active-high reset (aborts any frame)
//   tx_data   in   byte to send; bits [DATA_BITS-1:0] are used
//   tx_valid  in   tx_data is valid
//   tx_ready  out  byte can be accepted this cycle
//   tx        out  serial line, driven straight from a flop
//   tx_idle   out  no frame in progress (same as tx_ready)
//   tx_done   out  high on the final cycle of the last stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_idle,
  output logic       tx_done
);

  localparam logic [7:0] DATA_MASK  = 8'((16'd1 << DATA_BITS) - 16'd1);
  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
  localparam bit         HAS_PARITY = (PARITY != PAR_NONE);

  uart_tx_state_t state_q;
  logic [7:0]     shift_q;
  logic [2:0]     bit_idx_q;
  logic           stop_idx_q;
  logic           par_q;
  logic           tx_q;
  logic           bit_end;
  logic           par_bit;

  // Every state change other than leaving IDLE happens on bit_end, where the
  // divider wraps by itself. Holding it clear in IDLE is therefore enough to
  // start each frame on a fresh bit period.
  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == S_IDLE),
    .bit_end(bit_end)
  );

  assign par_bit  = (^(tx_data & DATA_MASK)) ^ (PARITY == PAR_ODD);

  assign tx       = tx_q;
  assign tx_ready = (state_q == S_IDLE);
  assign tx_idle  = tx_ready;
  assign tx_done  = (state_q == S_STOP) && bit_end && (stop_idx_q == LAST_STOP);

  // tx_q always holds the level of the bit currently on the line. Each
  // transition loads the level of the bit that follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (tx_valid) begin
            shift_q    <= tx_data & DATA_MASK;
            par_q      <= par_bit;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q != LAST_BIT) begin
              tx_q <= shift_q[1];
            end else if (HAS_PARITY) begin
              tx_q    <= par_q;
              state_q <= S_PARITY;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            if (stop_idx_q == LAST_STOP) state_q <= S_IDLE;
            else                         stop_idx_q <= 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Four instances share one clock: 8N1, 8E1, 8O1 and 8N2, all with CLK_DIV=4.
// Expected per-cycle line/done/ready values are pushed to a queue as frames
// are launched and popped as the DUT produces them.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DIV = 4;

  typedef struct packed {
    logic tx;
    logic done;
    logic rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic [3:0] rst;
  logic [3:0] valid;
  logic [7:0] data [4];
  logic [3:0] tx, rdy, idle, done;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst[0]), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(rdy[0]), .tx(tx[0]), .tx_idle(idle[0]), .tx_done(done[0]));

  uart_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst[1]), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(rdy[1]), .tx(tx[1]), .tx_idle(idle[1]), .tx_done(done[1]));

  uart_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst[2]), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(rdy[2]), .tx(tx[2]), .tx_idle(idle[2]), .tx_done(done[2]));

  uart_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst[3]), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(rdy[3]), .tx(tx[3]), .tx_idle(idle[3]), .tx_done(done[3]));

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference frame: one queue entry per clock cycle of the frame.
  task automatic push_frame(input logic [7:0] d, input int bits, input int par, input int stop);
    logic bq[$];
    logic p;
    exp_t e;
    p = 1'b0;
    bq.push_back(1'b0);
    for (int j = 0; j < bits; j++) begin
      bq.push_back(d[j]);
      p = p ^ d[j];
    end
    if (par == PAR_EVEN) bq.push_back(p);
    if (par == PAR_ODD)  bq.push_back(~p);
    for (int s = 0; s < stop; s++) bq.push_back(1'b1);
    for (int i = 0; i < bq.size(); i++) begin
      for (int c = 0; c < DIV; c++) begin
        e.tx   = bq[i];
        e.rdy  = 1'b0;
        e.done = (i == bq.size() - 1) && (c == DIV - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e.tx = 1'b1; e.done = 1'b0; e.rdy = 1'b1;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // Advance one cycle and compare the instance's outputs with the next entry.
  task automatic step(input int idx, input string tag);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".tx"},   tx[idx],   e.tx);
      check({tag, ".done"}, done[idx], e.done);
      check({tag, ".rdy"},  rdy[idx],  e.rdy);
      check({tag, ".idle"}, idle[idx], e.rdy);
    end
  endtask

  // Launch one frame and follow it through to one idle cycle afterwards.
  task automatic send(input int idx, input logic [7:0] d, input int par, input int stop, input string name);
    int len;
    len = frame_cycles(DIV, 8, par, stop);
    check({name, ".ready_pre"}, rdy[idx], 1'b1);
    data[idx]  = d;
    valid[idx] = 1'b1;
    push_frame(d, 8, par, stop);
    push_idle(1);
    for (int k = 1; k <= len + 1; k++) begin
      step(idx, $sformatf("%s[%0d]", name, k));
      if (k == 1) begin
        valid[idx] = 1'b0;
        data[idx]  = ~d;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within 200 us");
    $fatal(1);
  end

  initial begin
    rst   = 4'hF;
    valid = 4'h0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 4'h0;

    // Reset/idle: line high, ready high, no done, for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rst_idle%0d[%0d].tx", i, c),   tx[i],   1'b1);
        check($sformatf("rst_idle%0d[%0d].rdy", i, c),  rdy[i],  1'b1);
        check($sformatf("rst_idle%0d[%0d].done", i, c), done[i], 1'b0);
      end
    end

    // Basic 8N1 frame, parity frames, two stop bits.
    send(0, 8'hA5, PAR_NONE, 1, "8n1_a5");
    send(1, 8'hA5, PAR_EVEN, 1, "8e1_a5");
    send(2, 8'hA5, PAR_ODD,  1, "8o1_a5");
    send(3, 8'h00, PAR_NONE, 2, "8n2_00");

    // Back-to-back with tx_valid held; data changes right after the first handshake.
    check("b2b.ready_pre", rdy[0], 1'b1);
    data[0]  = 8'h55;
    valid[0] = 1'b1;
    push_frame(8'h55, 8, PAR_NONE, 1);
    push_idle(1);
    push_frame(8'h0F, 8, PAR_NONE, 1);
    push_idle(1);
    for (int k = 1; k <= 82; k++) begin
      step(0, $sformatf("b2b[%0d]", k));
      if (k == 1)  data[0]  = 8'h0F;
      if (k == 42) valid[0] = 1'b0;
    end

    // Reset during data bit 3 of 0xFF (bit 3 spans cycles 17..20).
    check("rst_mid.ready_pre", rdy[0], 1'b1);
    data[0]  = 8'hFF;
    valid[0] = 1'b1;
    push_frame(8'hFF, 8, PAR_NONE, 1);
    for (int k = 1; k <= 18; k++) begin
      step(0, $sformatf("rst_mid[%0d]", k));
      if (k == 1) valid[0] = 1'b0;
    end
    sb.delete();
    rst[0] = 1'b1;
    push_idle(3);
    step(0, "rst_mid_abort");
    rst[0] = 1'b0;
    step(0, "rst_mid_post1");
    step(0, "rst_mid_post2");
    send(0, 8'h3C, PAR_NONE, 1, "after_rst_3c");

    // Reset and tx_valid together: reset wins and the byte is dropped.
    rst[1]   = 1'b1;
    valid[1] = 1'b1;
    data[1]  = 8'h80;
    push_idle(4);
    step(1, "rst_vs_valid0");
    rst[1]   = 1'b0;
    valid[1] = 1'b0;
    for (int k = 1; k <= 3; k++) step(1, $sformatf("rst_vs_valid%0d", k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
